// File: rtl/uart_pkg.sv
// uart_pkg: UART constants and receiver state encodings, shared by the receiver and transmitter.
package uart_pkg;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_e;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  assign q_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first receiver sampling mid-bit, with frame-error detection and break hold-off.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic       uart_rx_irq,
  output logic [7:0] uart_rx_byte,
  output logic       frame_err_o,
  output logic       busy_o
);
  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
  uart_rx_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d, byte_q, byte_d;
  logic irq_q, irq_d, ferr_q, ferr_d;
  logic rx_s;
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    irq_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        state_d = rx_s ? IDLE : START;
      end
      START:
        if (timer_q == HALF_M1) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      DATA:
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          state_d = (idx_q == 3'd7) ? STOP : DATA;
        end
      STOP:
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          byte_d  = rx_s ? shift_q : byte_q;
          irq_d   = rx_s;
          ferr_d  = !rx_s;
          state_d = rx_s ? IDLE : BREAK;
        end
      BREAK: begin
        timer_d = '0;
        state_d = rx_s ? IDLE : BREAK;
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      irq_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      irq_q   <= irq_d;
      ferr_q  <= ferr_d;
    end
  assign uart_rx_irq  = irq_q;
  assign uart_rx_byte = byte_q;
  assign frame_err_o  = ferr_q;
  assign busy_o       = state_q != IDLE;
endmodule
